// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains fifo_mem one byte at a time and serialises it as a
// UART frame (start, 8 data LSB first, optional parity, STOP_BITS stop).
// Ports: clk, rst_n (sync, active-low), tx_en, fifo_empty, fifo_data[7:0]
//   in; fifo_rd (pop strobe), tx (serial line), busy, tx_done out.
// Build option: define FIFO_UART_TX_PARITY_EN to insert a parity bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          tx_nxt, rd_nxt, busy_nxt, done_nxt;
  logic          bit_end;
  logic [CW-1:0] cnt_inc;

`ifdef FIFO_UART_TX_PARITY_EN
  logic par, par_nxt;
`endif

  assign bit_end = (cnt == CNT_LAST);
  assign cnt_inc = bit_end ? '0 : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    tx_nxt    = tx;
    rd_nxt    = 1'b0;
    done_nxt  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_nxt   = par;
`endif
    unique case (state)
      IDLE: begin
        tx_nxt  = 1'b1;
        cnt_nxt = '0;
        idx_nxt = '0;
        if (tx_en && !fifo_empty) begin
          state_nxt = FETCH;
          rd_nxt    = 1'b1;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        // fifo_mem shows the popped byte one cycle after the strobe
        sh_nxt    = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        par_nxt   = (^fifo_data) ^ PARITY_ODD[0];
`endif
        tx_nxt    = 1'b0;
        cnt_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        cnt_nxt = cnt_inc;
        if (bit_end) begin
          tx_nxt    = sh[0];
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        cnt_nxt = cnt_inc;
        if (bit_end) begin
          if (idx == 3'd7) begin
            idx_nxt   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            tx_nxt    = par;
            state_nxt = PARITY;
`else
            tx_nxt    = 1'b1;
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = idx + 3'd1;
            sh_nxt  = sh >> 1;
            tx_nxt  = sh[1];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        cnt_nxt = cnt_inc;
        if (bit_end) begin
          tx_nxt    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        cnt_nxt = cnt_inc;
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      tx      <= 1'b1;
      fifo_rd <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      sh      <= sh_nxt;
      tx      <= tx_nxt;
      fifo_rd <= rd_nxt;
      busy    <= busy_nxt;
      tx_done <= done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed + random frames for fifo_uart_tx against a
// bit-list frame model and a simple in-bench FIFO.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int SB    = 1;
  localparam int P_ODD = 0;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd, tx, busy, tx_done;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(SB),
    .PARITY_ODD(P_ODD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_en(tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk)
    if (fifo_rd && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end

  int cyc = 0;
  int rd_count = 0;
  int rd_cyc = -100;
  int underflows = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      rd_count <= rd_count + 1;
      rd_cyc   <= cyc;
      if (fifo_empty) underflows <= underflows + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr++;
    exp_q.push_back(b);
  endtask

  task automatic wait_start(output int s);
    s = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx === 1'b0) begin
        s = cyc;
        break;
      end
      chk("gap_tx", tx, 1);
      chk("done_once", tx_done, 0);
    end
    if (s < 0) chk("start_timeout", 0, 1);
  endtask

  // Expected frame built as a plain list of line levels.
  task automatic check_frame(input logic [7:0] b, input int drop_bit,
                             output int s, output int e);
    bit seq[$];
    wait_start(s);
    chk("pop_to_start", rd_cyc, s - 2);
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(b[i]);
    if (PB == 1) seq.push_back((^b) ^ P_ODD[0]);
    for (int i = 0; i < SB; i++) seq.push_back(1'b1);
    for (int i = 0; i < seq.size(); i++)
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) step();
        if (i == drop_bit && c == 0) tx_en = 1'b0;
        chk("tx_bit", tx, seq[i]);
        chk("busy_hi", busy, 1);
        chk("done_lo", tx_done, 0);
        chk("rd_lo", fifo_rd, 0);
      end
    e = cyc;
    step();
    chk("tx_done", tx_done, 1);
    chk("busy_drop", busy, 0);
    chk("tx_idle", tx, 1);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_tx", tx, 1);
      chk("idle_rd", fifo_rd, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, prev_e, base;
    logic [7:0] b;

    // reset state
    repeat (3) step();
    chk("rst_tx", tx, 1);
    chk("rst_rd", fifo_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    rst_n = 1'b1;
    step();

    // single frame
    tx_en = 1'b1;
    push(8'hA5);
    b = exp_q.pop_front();
    check_frame(b, -1, s, e);
    chk("single_rd_cnt", rd_count, 1);

    // back-to-back, directed then random bytes
    base = rd_count;
    push(8'h01); push(8'h02); push(8'h03); push(8'h07);
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    prev_e = 0;
    for (int k = 0; k < 8; k++) begin
      b = exp_q.pop_front();
      check_frame(b, -1, s, e);
      if (k > 0) chk("b2b_gap", s - prev_e, 4);
      prev_e = e;
    end
    chk("b2b_rd_cnt", rd_count - base, 8);
    idle_check(10);

    // empty with enable, then data with enable low
    base = rd_count;
    idle_check(100);
    tx_en = 1'b0;
    push(8'h5A);
    idle_check(100);
    chk("disabled_rd_cnt", rd_count - base, 0);
    tx_en = 1'b1;
    b = exp_q.pop_front();
    check_frame(b, -1, s, e);

    // tx_en dropped mid-frame with two queued
    base = rd_count;
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    b = exp_q.pop_front();
    check_frame(b, 4, s, e);
    idle_check(30);
    chk("drop_rd_cnt", rd_count - base, 1);
    tx_en = 1'b1;
    b = exp_q.pop_front();
    check_frame(b, -1, s, e);
    chk("resume_rd_cnt", rd_count - base, 2);

    // reset during data bit 3 of 0xFF
    base = rd_count;
    push(8'hFF);
    push(8'h3C);
    wait_start(s);
    b = exp_q.pop_front();
    while (cyc < s + 4 * CPB + 1) step();
    chk("pre_rst_tx", tx, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd", fifo_rd, 0);
    chk("mid_rst_done", tx_done, 0);
    rst_n = 1'b1;
    b = exp_q.pop_front();
    check_frame(b, -1, s, e);
    chk("rst_rd_cnt", rd_count - base, 2);

    idle_check(5);
    chk("underflows", underflows, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for fifo_mem. Pops one byte at a time from the FIFO read port and serialises it as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, stop bit(s). Sits between fifo_mem and the board TX pin. Stalls cleanly when the FIFO is empty or transmission is disabled.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit; legal minimum is 2.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
PARITY_ODD, 0, parity sense, used only when PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  synchronous active-low reset.
tx_en  input  1  transmit enable; sampled only in IDLE.
fifo_empty  input  1  from fifo_mem fifo_empty.
fifo_data  input  8  from fifo_mem data_out.
fifo_rd  output  1  to fifo_mem rd; one-cycle pop strobe.
tx  output  1  serial line; idles high.
busy  output  1  high from FETCH through the end of STOP.
tx_done  output  1  one-cycle pulse on frame completion.

Behaviour:
- One clock domain. Reset is synchronous and active-low (rst_n sampled on the clk rising edge). All outputs are registered.
- Reset values: tx=1, fifo_rd=0, busy=0, tx_done=0, state=IDLE, counters=0.
- States: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE
  - If tx_en=1 and fifo_empty=0 at an edge, go to FETCH.
  - fifo_rd=1 during the FETCH cycle only, exactly one cycle per frame.
  - No pop is ever issued while fifo_empty=1, so fifo_underflow is never caused by this block.
- FETCH -> LOAD: unconditional. fifo_mem presents popped data during the cycle after the strobe.
- LOAD: at the LOAD-exit edge, fifo_data is captured into an 8-bit shift register and tx drives 0 (start bit begins).
- Bit timing
  - Each bit lasts exactly CLKS_PER_BIT cycles, measured by a $clog2(CLKS_PER_BIT)-bit counter.
  - The counter counts 0..CLKS_PER_BIT-1 and then reloads 0.
- DATA: 8 bits LSB first; the shift register shifts right at each bit boundary. A 3-bit index counts 0..7.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle, tx_done is registered high for exactly 1 cycle.
  - Return to IDLE on the same edge.
- Back-to-back frames: if the FIFO is still non-empty and tx_en=1, the next start bit falls 3 cycles after the last stop cycle ends (IDLE, FETCH, LOAD). Between frames tx stays 1.
- Latency: from the IDLE edge where the condition is sampled true, fifo_rd rises 1 cycle later and tx falls 3 cycles later.
- tx_en dropped mid-frame: the current frame completes; no new fetch is made.
- fifo_empty changes mid-frame: ignored; evaluated only in IDLE.
- Reset mid-frame: on the reset edge, tx=1 and all outputs/state return to reset values. The partially sent byte is discarded, with no re-pop.
- busy=0 only in IDLE.

Optional Feature:
- FIFO_UART_TX_PARITY_EN defined:
  - A PARITY state of CLKS_PER_BIT cycles is inserted between DATA and STOP.
  - Parity bit = XOR of the 8 data bits, inverted when PARITY_ODD=1.
  - Frame = 11 bits + (STOP_BITS-1).
- Not defined: no PARITY state and no parity logic; frame = 10 bits + (STOP_BITS-1). The PARITY_ODD parameter is accepted but unused.

Test Plan:
1. Single frame. CLKS_PER_BIT=4, no parity; FIFO holds 0xA5; tx_en=1.
   -> fifo_rd high 1 cycle.
   -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; frame 40 cycles.
   -> tx_done pulses once; busy drops with tx_done.
2. Back-to-back. FIFO holds 0x01, 0x02, 0x03.
   -> 3 frames, each 40 cycles, with 3 idle-high cycles between them.
   -> Exactly 3 fifo_rd pulses; block returns to IDLE when fifo_empty=1.
3. Empty/disabled.
   -> fifo_empty=1 with tx_en=1: fifo_rd never asserts, tx stays 1 for 100 cycles.
   -> FIFO non-empty with tx_en=0: same result.
4. Reset mid-frame. Pulse rst_n low for 1 cycle during data bit 3 of 0xFF.
   -> tx=1, busy=0 on the next cycle.
   -> Next frame starts clean with the next FIFO byte.
5. Parity (FIFO_UART_TX_PARITY_EN).
   -> PARITY_ODD=0, byte 0xA5: parity bit 0.
   -> PARITY_ODD=0, byte 0x07: parity bit 1.
   -> PARITY_ODD=1, byte 0xA5: parity bit 1.
   -> Frame length 44 cycles.
6. tx_en drop. Deassert tx_en mid-frame with 2 bytes queued.
   -> Current frame completes; no further fifo_rd.
   -> Re-assert tx_en: second byte is sent.
